// File: rtl/tile_config_loader.sv
// rtl/tile_config_loader.sv - streams a checksummed configuration image into one logic tile
module tile_config_loader #(
  parameter int CONFIG_WIDTH = 194,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cfg_start,
  input  logic                    cfg_valid,
  input  logic [WORD_WIDTH-1:0]   cfg_data,
  output logic                    cfg_ready,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    tile_nreset,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int NUM_WORDS = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    DONE,
    ERROR
  } state_t;

  state_t                  state;
  logic [CONFIG_WIDTH-1:0] shadow;
  logic [CONFIG_WIDTH-1:0] shadow_next;
  logic [CNT_W-1:0]        word_cnt;
  logic [WORD_WIDTH-1:0]   checksum;
  logic                    xfer;

  assign xfer = cfg_valid & cfg_ready;

  // Each word lane of the shadow takes cfg_data when the counter points at it.
  // The last lane is narrowed so padding bits above CONFIG_WIDTH never land anywhere.
  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_lane
    localparam int LO = k * WORD_WIDTH;
    localparam int HI = (LO + WORD_WIDTH > CONFIG_WIDTH) ? CONFIG_WIDTH - 1 : LO + WORD_WIDTH - 1;
    assign shadow_next[HI:LO] = (word_cnt == CNT_W'(k)) ? cfg_data[HI-LO:0] : shadow[HI:LO];
  end

  // Load sequencer: start/restart, word capture with running XOR, checksum compare and commit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shadow      <= '0;
      word_cnt    <= '0;
      checksum    <= '0;
      config_out  <= '0;
      cfg_ready   <= 1'b0;
      tile_nreset <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else if (cfg_start) begin
      // A start wins over any word presented in the same cycle; that word is dropped.
      state       <= LOAD;
      shadow      <= '0;
      word_cnt    <= '0;
      checksum    <= '0;
      cfg_ready   <= 1'b1;
      tile_nreset <= 1'b0;
      busy        <= 1'b1;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (xfer) begin
            shadow   <= shadow_next;
            checksum <= checksum ^ cfg_data;
            if (word_cnt == LAST_WORD) begin
              state <= CHECK;
            end else begin
              word_cnt <= word_cnt + CNT_W'(1);
            end
          end
        end
        CHECK: begin
          // Counter stays parked on the last word; the next word is the checksum.
          if (xfer) begin
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
            if (cfg_data == checksum) begin
              state       <= DONE;
              done        <= 1'b1;
              tile_nreset <= 1'b1;
              config_out  <= shadow;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
        end
        default: begin
          // IDLE, DONE and ERROR hold until a start or reset.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_config_loader.sv
// tb/tb_tile_config_loader.sv - scoreboard bench for tile_config_loader
module tb_tile_config_loader;

  localparam int CW = 194;
  localparam int WW = 8;
  localparam int NW = 25;

  logic          clock = 1'b0;
  logic          reset;
  logic          cfg_start;
  logic          cfg_valid;
  logic [WW-1:0] cfg_data;
  logic          cfg_ready;
  logic [CW-1:0] config_out;
  logic          tile_nreset;
  logic          busy;
  logic          done;
  logic          error;

  tile_config_loader #(.CONFIG_WIDTH(CW), .WORD_WIDTH(WW)) dut (
    .clock      (clock),
    .reset      (reset),
    .cfg_start  (cfg_start),
    .cfg_valid  (cfg_valid),
    .cfg_data   (cfg_data),
    .cfg_ready  (cfg_ready),
    .config_out (config_out),
    .tile_nreset(tile_nreset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic          done_v;
    logic          error_v;
    logic [CW-1:0] cfg;
    int            at_cyc;
  } exp_t;

  exp_t          sb[$];
  logic [WW-1:0] words[NW];
  logic [CW-1:0] exp_cfg;

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  task automatic check_cfg(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference packing: word k fills bits [8k+7:8k], bits at or above CW are dropped.
  function automatic logic [CW-1:0] pack();
    logic [CW-1:0] r;
    r = '0;
    for (int k = 0; k < NW; k++) begin
      for (int b = 0; b < WW; b++) begin
        int idx;
        idx = k * WW + b;
        if (idx < CW) r[idx] = words[k][b];
      end
    end
    return r;
  endfunction

  // Monitor: pops an expectation whenever done or error rises, and flags any other config_out change.
  logic          mon_pd = 1'b0;
  logic          mon_pe = 1'b0;
  logic [CW-1:0] mon_pc = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if ((done && !mon_pd) || (error && !mon_pe)) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result actual done=%b error=%b required=no result", done, error);
          end else begin
            e = sb.pop_front();
            check_bit("done", done, e.done_v);
            check_bit("error", error, e.error_v);
            check_bit("tile_nreset", tile_nreset, e.done_v);
            check_bit("busy_at_result", busy, 1'b0);
            check_cfg("config_out", config_out, e.cfg);
            check_int("result_cycle", cyc, e.at_cyc);
          end
        end else if (config_out !== mon_pc) begin
          checks++;
          failures++;
          $display("FAIL config_out_stray_change actual=%h required=%h", config_out, mon_pc);
        end
      end
      mon_pd = done;
      mon_pe = error;
      mon_pc = config_out;
    end
  end

  task automatic pulse_start();
    @(negedge clock);
    cfg_start = 1'b1;
    @(posedge clock);
    #1 cfg_start = 1'b0;
  endtask

  task automatic send_word(input logic [WW-1:0] d);
    int n;
    n = 0;
    @(negedge clock);
    while (!cfg_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!cfg_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual cfg_ready=%b required=1", cfg_ready);
    end
    cfg_valid = 1'b1;
    cfg_data  = d;
    @(posedge clock);
    #1;
    cfg_valid = 1'b0;
    cfg_data  = 8'h5A;
  endtask

  task automatic run_load(input logic [WW-1:0] cks, input bit gaps, input bit do_start,
                          input bit ok, input logic [CW-1:0] cfg_ok);
    exp_t e;
    if (do_start) pulse_start();
    for (int i = 0; i < NW; i++) begin
      send_word(words[i]);
      if (gaps && (i % 3 == 0)) begin
        cfg_data = 8'hC3;
        repeat (2) @(posedge clock);
        #1;
      end
    end
    send_word(cks);
    if (ok) exp_cfg = cfg_ok;
    e.done_v  = ok;
    e.error_v = !ok;
    e.cfg     = exp_cfg;
    e.at_cyc  = cyc;
    sb.push_back(e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    exp_cfg   = '0;
    repeat (2) @(posedge clock);
    #1;
    check_cfg("reset_config_out", config_out, '0);
    check_bit("reset_tile_nreset", tile_nreset, 1'b0);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_done", done, 1'b0);
    check_bit("reset_error", error, 1'b0);
    check_bit("reset_cfg_ready", cfg_ready, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    // IDLE ignores cfg_valid
    cfg_valid = 1'b1;
    cfg_data  = 8'h77;
    repeat (3) @(posedge clock);
    #1 cfg_valid = 1'b0;
    check_bit("idle_busy", busy, 1'b0);
    check_bit("idle_cfg_ready", cfg_ready, 1'b0);

    // Good load: 0x00..0x18, checksum 0x18
    for (int i = 0; i < NW; i++) words[i] = 8'(i);
    run_load(8'h18, 1'b0, 1'b1, 1'b1, pack());
    check_cfg("good_low_bytes", config_out[31:0], {162'b0, 32'h03020100});
    check_bit("good_done_next_cycle", done, 1'b1);

    // DONE ignores cfg_valid
    @(negedge clock);
    cfg_valid = 1'b1;
    cfg_data  = 8'h11;
    repeat (3) @(posedge clock);
    #1 cfg_valid = 1'b0;
    check_bit("done_hold", done, 1'b1);
    check_bit("done_cfg_ready", cfg_ready, 1'b0);

    // Bad checksum: 25 x 0xFF, checksum 0x00 instead of 0xFF
    for (int i = 0; i < NW; i++) words[i] = 8'hFF;
    run_load(8'h00, 1'b0, 1'b1, 1'b0, '0);

    // Padding: only word 24 = 0xFD
    for (int i = 0; i < NW; i++) words[i] = 8'h00;
    words[24] = 8'hFD;
    run_load(8'hFD, 1'b0, 1'b1, 1'b1, {2'b01, 192'b0});

    // Gapped load, 1,0,0,1 valid pattern, same data as the good load
    for (int i = 0; i < NW; i++) words[i] = 8'(i);
    run_load(8'h18, 1'b1, 1'b1, 1'b1, pack());

    // Restart at word 10 with a simultaneous valid word that must be dropped
    pulse_start();
    for (int i = 0; i < 10; i++) send_word(8'h40 + 8'(i));
    @(negedge clock);
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 8'hAA;
    @(posedge clock);
    #1;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    for (int i = 0; i < NW; i++) words[i] = 8'h80 + 8'(i);
    run_load(8'h98, 1'b0, 1'b0, 1'b1, pack());

    // Mid-load reset at word 12
    pulse_start();
    for (int i = 0; i < 12; i++) send_word(8'(i));
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check_cfg("midreset_config_out", config_out, '0);
    check_bit("midreset_tile_nreset", tile_nreset, 1'b0);
    check_bit("midreset_busy", busy, 1'b0);
    check_bit("midreset_done", done, 1'b0);
    check_bit("midreset_error", error, 1'b0);
    check_bit("midreset_cfg_ready", cfg_ready, 1'b0);
    exp_cfg = '0;
    @(negedge clock);
    #1 reset = 1'b0;
    cfg_valid = 1'b1;
    cfg_data  = 8'h33;
    repeat (3) @(posedge clock);
    #1 cfg_valid = 1'b0;
    check_bit("post_reset_busy", busy, 1'b0);
    check_bit("post_reset_cfg_ready", cfg_ready, 1'b0);

    // Recovery load after reset
    for (int i = 0; i < NW; i++) words[i] = 8'(i);
    run_load(8'h18, 1'b0, 1'b1, 1'b1, pack());

    begin
      int n;
      n = 0;
      while (sb.size() != 0 && n < 20) begin
        @(posedge clock);
        n++;
      end
      if (sb.size() != 0) begin
        checks++;
        failures++;
        $display("FAIL result_drain actual pending=%0d required=0", sb.size());
      end
    end
    repeat (2) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
